cacheline_mem_adapter: RTL and testbench
========================================

// Module: cacheline_mem_adapter
// PURPOSE
//   Requester-side adapter between the L2/cache line interface and the burst main-memory port served by
//   ParamMemory. Turns one 256-bit line read/write into a 4-beat 64-bit burst transaction, assembles read
//   bursts into a line, and returns a single-cycle completion to the cache. Sits between cache and memory in the DUT.
// PARAMETERS
//   LINE_W   256  cache line width in bits
//   BURST_W  64   memory data beat width; BEATS = LINE_W/BURST_W (4)
//   ADDR_W   32   byte address width; line offset bits = log2(LINE_W/8) (5)
// PORTS
//   clk        in   1        clock; all logic on posedge
//   rst        in   1        synchronous, active-high reset
//   line_i     in   LINE_W   write line from cache
//   address_i  in   ADDR_W   line byte address from cache
//   read_i     in   1        line read request, held until resp_o
//   write_i    in   1        line write request, held until resp_o
//   line_o     out  LINE_W   assembled read line
//   resp_o     out  1        1-cycle completion pulse to cache
//   burst_i    in   BURST_W  read beat from memory
//   resp_i     in   1        memory beat strobe (one per beat)
//   burst_o    out  BURST_W  write beat to memory
//   address_o  out  ADDR_W   line-aligned memory address
//   read_o     out  1        memory read request
//   write_o    out  1        memory write request
// BEHAVIOUR
//   - Reset: state=IDLE, beat cnt=0, read_o=write_o=resp_o=0, address_o=0, burst_o=0, line_o=0.
//   - FSM: IDLE -> RD (read) | WR (write) -> DONE -> IDLE.
//   - IDLE: sample read_i/write_i. Both high: write wins. On accept, latch address_i[ADDR_W-1:5] with low 5 bits
//     forced 0 into address_o, latch line_i into wr buffer, cnt=0. read_o/write_o go high the cycle after accept.
//   - RD: read_o=1. Each cycle resp_i=1: burst_i -> line bits [64*cnt+63 : 64*cnt], cnt++. Beats need not be
//     consecutive; cnt advances only on resp_i. On the cycle the 4th beat (cnt==3) is sampled -> DONE;
//     read_o drops the following cycle.
//   - WR: write_o=1, burst_o = wr_buf[64*cnt+63 : 64*cnt] combinationally from cnt. Each resp_i advances cnt;
//     on 4th resp_i -> DONE; write_o drops the following cycle.
//   - DONE: resp_o=1 for exactly one cycle; line_o holds assembled line (reads) and stays stable until the next
//     read completes; writes leave line_o unchanged. Next cycle IDLE. New request accepted no earlier than
//     the cycle after DONE (requests still high during DONE are not re-accepted that cycle).
//   - Latency: accept at edge N; read_o high N+1; with beats at N+1+L..N+4+L, resp_o at N+5+L.
//   - resp_i in IDLE/DONE ignored; read_i/write_i changes while RD/WR ignored (cache must hold them).
//   - cnt is 2 bits, never wraps mid-transaction; reset to 0 on every accept.
//   - address_o/burst_o undefined to memory when read_o=write_o=0 but held at last value (no X).
//   - rst mid-transaction: IDLE next edge, read_o/write_o/resp_o low, partial line discarded, line_o=0.
// TESTING
//   1 Read addr 0x0000_1234, beats 0x11..,0x22..,0x33..,0x44.. back-to-back -> address_o=0x0000_1220,
//     line_o={0x44..,0x33..,0x22..,0x11..}, resp_o one pulse, read_o low next cycle.
//   2 Write line {D3,D2,D1,D0} to 0x40 with 2-cycle gaps between resp_i -> burst_o=D0,D1,D2,D3 in order,
//     write_o held through 4th beat, single resp_o.
//   3 read_i and write_i both high in IDLE -> write transaction only (write_o=1, read_o=0).
//   4 Spurious resp_i in IDLE, then read -> cnt unaffected, line assembled correctly from real beats.
//   5 rst asserted after 2 read beats -> next cycle read_o=0, resp_o=0, line_o=0; fresh read then completes.
//   6 Back-to-back read then write with request held through resp_o -> no double accept, two resp_o pulses.

Source files
------------

// File: rtl/cacheline_mem_adapter_if.sv
// Bundle of cache-side and memory-side signals around the line/burst adapter.
// The slave modport is the adapter's view; master is the cache+memory side.
interface cacheline_mem_adapter_if #(
  parameter int LINE_W  = 256,
  parameter int BURST_W = 64,
  parameter int ADDR_W  = 32
);
  // cache side
  logic [LINE_W-1:0]  line_i;
  logic [ADDR_W-1:0]  address_i;
  logic               read_i;
  logic               write_i;
  logic [LINE_W-1:0]  line_o;
  logic               resp_o;
  // memory side
  logic [BURST_W-1:0] burst_i;
  logic               resp_i;
  logic [BURST_W-1:0] burst_o;
  logic [ADDR_W-1:0]  address_o;
  logic               read_o;
  logic               write_o;

  modport slave (
    input  line_i, address_i, read_i, write_i, burst_i, resp_i,
    output line_o, resp_o, burst_o, address_o, read_o, write_o
  );

  modport master (
    output line_i, address_i, read_i, write_i, burst_i, resp_i,
    input  line_o, resp_o, burst_o, address_o, read_o, write_o
  );
endinterface

// File: rtl/cacheline_mem_adapter.sv
// Converts one cache-line read/write into a BEATS-beat burst on the memory
// port, assembles read beats into a line and pulses a one-cycle completion.
module cacheline_mem_adapter #(
  parameter int LINE_W  = 256,
  parameter int BURST_W = 64,
  parameter int ADDR_W  = 32
) (
  input  logic                   clk,
  input  logic                   rst,
  cacheline_mem_adapter_if.slave bus
);
  localparam int BEATS = LINE_W / BURST_W;
  localparam int CNT_W = $clog2(BEATS);
  localparam logic [ADDR_W-1:0] OFF_MASK = ADDR_W'(LINE_W / 8 - 1);
  localparam logic [CNT_W-1:0]  LAST_CNT = CNT_W'(BEATS - 1);

  typedef enum logic [1:0] {IDLE, RD, WR, DONE} state_t;

  state_t                          state_reg, state_next;
  logic [CNT_W-1:0]                cnt_reg;
  logic [ADDR_W-1:0]               addr_reg;
  logic [BEATS-1:0][BURST_W-1:0]   wr_buf_reg;
  logic [BEATS-2:0][BURST_W-1:0]   rd_buf_reg;
  logic [BEATS-1:0][BURST_W-1:0]   line_reg;

  logic rd_req, wr_req, done_pulse;
  logic accept, last_beat, rd_last;

  // Beat counter reaching its final value with a strobe ends the burst.
  assign last_beat = bus.resp_i && (cnt_reg == LAST_CNT);
  assign rd_last   = (state_reg == RD) && last_beat;

  // Next-state and request/response outputs; write wins when both requests are high.
  always_comb begin
    state_next = state_reg;
    rd_req     = 1'b0;
    wr_req     = 1'b0;
    done_pulse = 1'b0;
    accept     = 1'b0;
    case (state_reg)
      IDLE: begin
        if (bus.write_i) begin
          accept     = 1'b1;
          state_next = WR;
        end else if (bus.read_i) begin
          accept     = 1'b1;
          state_next = RD;
        end
      end
      RD: begin
        rd_req = 1'b1;
        if (last_beat) state_next = DONE;
      end
      WR: begin
        wr_req = 1'b1;
        if (last_beat) state_next = DONE;
      end
      DONE: begin
        done_pulse = 1'b1;
        state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk) begin
    if (rst) state_reg <= IDLE;
    else     state_reg <= state_next;
  end

  // Request capture and beat counting; the counter parks on the last beat so
  // burst_o keeps showing the final write beat once the burst is over.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_reg    <= '0;
      addr_reg   <= '0;
      wr_buf_reg <= '0;
    end else if (accept) begin
      cnt_reg    <= '0;
      addr_reg   <= bus.address_i & ~OFF_MASK;
      wr_buf_reg <= bus.line_i;
    end else if ((state_reg == RD || state_reg == WR) && bus.resp_i && !last_beat) begin
      cnt_reg <= cnt_reg + 1'b1;
    end
  end

  // Per-beat read assembly; line_o is only updated when a read completes so
  // the cache sees a stable line between reads.
  for (genvar gi = 0; gi < BEATS - 1; gi++) begin : g_rd_beat
    // Capture beat gi of an in-flight read.
    always_ff @(posedge clk) begin
      if (rst)
        rd_buf_reg[gi] <= '0;
      else if (state_reg == RD && bus.resp_i && cnt_reg == CNT_W'(gi))
        rd_buf_reg[gi] <= bus.burst_i;
    end

    // Publish beat gi into the output line on read completion.
    always_ff @(posedge clk) begin
      if (rst)          line_reg[gi] <= '0;
      else if (rd_last) line_reg[gi] <= rd_buf_reg[gi];
    end
  end

  // The final beat goes straight from the memory bus into the output line.
  always_ff @(posedge clk) begin
    if (rst)          line_reg[BEATS-1] <= '0;
    else if (rd_last) line_reg[BEATS-1] <= bus.burst_i;
  end

  assign bus.read_o    = rd_req;
  assign bus.write_o   = wr_req;
  assign bus.resp_o    = done_pulse;
  assign bus.address_o = addr_reg;
  assign bus.burst_o   = wr_buf_reg[cnt_reg];
  assign bus.line_o    = line_reg;
endmodule

// File: tb/tb_cacheline_mem_adapter.sv
// Randomised bench for cacheline_mem_adapter with a transaction-level model:
// expected line/beat/address values come from plain slicing and masking.
module tb_cacheline_mem_adapter;
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  cacheline_mem_adapter_if bus ();

  cacheline_mem_adapter dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int         checks = 0;
  int         passed = 0;
  logic [255:0] line_exp = '0;   // what line_o must show (last completed read)
  bit         in_done = 1'b0;    // previous transaction just pulsed resp_o

  task automatic check_eq(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    checks++;
    if (obs === exp) passed++;
    else $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [255:0] rand_line();
    logic [255:0] v;
    for (int k = 0; k < 8; k++) v[32*k +: 32] = $urandom;
    return v;
  endfunction

  // Idle cycles with no request; optional spurious memory strobes.
  task automatic idle(input int n, input bit spurious);
    bus.read_i  = 1'b0;
    bus.write_i = 1'b0;
    for (int i = 0; i < n; i++) begin
      bus.resp_i  = spurious ? 1'($urandom_range(0, 1)) : 1'b0;
      bus.burst_i = {$urandom, $urandom};
      step();
      check_eq("idle_resp", bus.resp_o, 1'b0);
      check_eq("idle_req", {bus.read_o, bus.write_o}, 2'b00);
      check_eq("idle_line", bus.line_o, line_exp);
    end
    bus.resp_i = 1'b0;
    in_done = 1'b0;
  endtask

  // One full line transaction. For reads 'line' supplies the memory beats,
  // for writes it is the cache line to be written.
  task automatic txn(input bit is_wr, input bit both, input logic [31:0] addr,
                     input logic [255:0] line, input int gmin, input int gmax);
    bit wr;
    logic [31:0] aexp;
    wr   = is_wr || both;
    aexp = addr & 32'hFFFF_FFE0;
    bus.address_i = addr;
    bus.line_i    = line;
    bus.read_i    = !is_wr || both;
    bus.write_i   = wr;
    bus.resp_i    = 1'b0;
    if (in_done) begin
      step();  // leaving DONE: held request must not be taken here
      check_eq("no_reaccept", {bus.resp_o, bus.read_o, bus.write_o}, 3'b000);
    end
    step();    // accept edge
    check_eq("req_rd", bus.read_o, !wr);
    check_eq("req_wr", bus.write_o, wr);
    check_eq("addr", bus.address_o, aexp);
    for (int k = 0; k < 4; k++) begin
      int gap;
      gap = $urandom_range(gmin, gmax);
      for (int g = 0; g < gap; g++) begin
        bus.resp_i  = 1'b0;
        bus.burst_i = {$urandom, $urandom};
        step();
        check_eq("hold_req", {bus.read_o, bus.write_o, bus.resp_o}, wr ? 3'b010 : 3'b100);
      end
      bus.resp_i  = 1'b1;
      bus.burst_i = line[64*k +: 64];
      if (wr) check_eq("burst_o", bus.burst_o, line[64*k +: 64]);
      step();
      if (k < 3) check_eq("early_resp", bus.resp_o, 1'b0);
    end
    bus.resp_i  = 1'b0;
    bus.burst_i = {$urandom, $urandom};
    if (!wr) line_exp = line;
    check_eq("resp_o", bus.resp_o, 1'b1);
    check_eq("req_drop", {bus.read_o, bus.write_o}, 2'b00);
    check_eq("line_o", bus.line_o, line_exp);
    in_done = 1'b1;
    $display("txn %s addr=%08h line=%064h", wr ? "WR" : "RD", aexp, line);
  endtask

  initial begin
    rst = 1'b1;
    bus.line_i = '0; bus.address_i = '0; bus.read_i = 1'b0; bus.write_i = 1'b0;
    bus.burst_i = '0; bus.resp_i = 1'b0;
    repeat (3) step();
    check_eq("rst_req", {bus.read_o, bus.write_o, bus.resp_o}, 3'b000);
    check_eq("rst_addr", bus.address_o, 32'h0);
    check_eq("rst_burst", bus.burst_o, 64'h0);
    check_eq("rst_line", bus.line_o, 256'h0);
    rst = 1'b0;
    idle(2, 1'b0);

    // 1: read with back-to-back beats, unaligned address
    txn(1'b0, 1'b0, 32'h0000_1234,
        {{16{4'h4}}, {16{4'h3}}, {16{4'h2}}, {16{4'h1}}}, 0, 0);
    idle(1, 1'b0);
    // 2: write with 2-cycle gaps
    txn(1'b1, 1'b0, 32'h0000_0040, rand_line(), 2, 2);
    idle(1, 1'b0);
    // 3: both requests high -> write only
    txn(1'b0, 1'b1, $urandom, rand_line(), 0, 1);
    // 4: spurious strobes while idle, then a read
    idle(4, 1'b1);
    txn(1'b0, 1'b0, $urandom, rand_line(), 0, 2);
    idle(1, 1'b0);

    // 5: reset after two read beats
    bus.address_i = 32'h0000_0800;
    bus.read_i    = 1'b1;
    step();
    for (int k = 0; k < 2; k++) begin
      bus.resp_i  = 1'b1;
      bus.burst_i = {$urandom, $urandom};
      step();
    end
    rst = 1'b1;
    step();
    line_exp = '0;
    check_eq("midrst_req", {bus.read_o, bus.write_o, bus.resp_o}, 3'b000);
    check_eq("midrst_line", bus.line_o, 256'h0);
    rst = 1'b0;
    idle(2, 1'b0);
    txn(1'b0, 1'b0, 32'h0000_0800, rand_line(), 0, 1);

    // 6: read then write back-to-back, request held through resp_o
    txn(1'b0, 1'b0, $urandom, rand_line(), 0, 1);
    txn(1'b1, 1'b0, $urandom, rand_line(), 0, 1);

    // random mix
    for (int t = 0; t < 24; t++) begin
      if ($urandom_range(0, 1) == 1) idle($urandom_range(1, 3), 1'b1);
      txn(1'($urandom_range(0, 1)), ($urandom_range(0, 3) == 0),
          $urandom, rand_line(), 0, 3);
    end
    idle(2, 1'b0);

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end
endmodule
